bcd_seq_addsub: RTL and testbench

BCD_SEQ_ADDSUB -- requirements
Module: bcd_seq_addsub

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_addsub.sv | 29 ++
 rtl/bcd_seq_addsub.sv | 161 ++++++++++++++++
 tb/tb_bcd_seq_addsub.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD adder/subtractor.
package bcd_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX     = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic bcd_digit_ok(input logic [BCD_DIGIT_W-1:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One-digit BCD add/subtract step: t = a + (b or 9-b) + c, decimal-corrected.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a_i,
   input  logic [BCD_DIGIT_W-1:0] b_i,
   input  logic                   sub,
   input  logic                   c,
   output logic [BCD_DIGIT_W-1:0] sum_i,
   output logic                   c_out
);

   logic [BCD_DIGIT_W-1:0] b_eff_s;
   logic [BCD_DIGIT_W:0]   t_s;

   // Nine's-complement the subtrahend digit, add, then wrap at ten.
   always_comb begin
      b_eff_s = sub ? (BCD_MAX - b_i) : b_i;
      t_s     = {1'b0, a_i} + {1'b0, b_eff_s} + {4'd0, c};
      if (t_s >= 5'd10) begin
         sum_i = 4'(t_s - 5'd10);
         c_out = 1'b1;
      end else begin
         sum_i = t_s[3:0];
         c_out = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_seq_addsub.sv
// Sequential packed-BCD adder/subtractor processing one digit per clock, LSD first.
module bcd_seq_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          sub,
   input  logic                          cin,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
   output logic                          cout,
   output logic                          err
);

   localparam int W     = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               sub_q, sub_d;
   logic               carry_q, carry_d;
   logic               err_pend_q, err_pend_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               operand_err_s;
   logic [BCD_DIGIT_W-1:0] dig_sum_s;
   logic [BCD_DIGIT_W-1:0] dig_wr_s;
   logic               dig_carry_s;

   // Operand registers shift right, so the active digit is always in the low nibble.
   bcd_digit_addsub u_digit (
      .a_i   (a_q[BCD_DIGIT_W-1:0]),
      .b_i   (b_q[BCD_DIGIT_W-1:0]),
      .sub   (sub_q),
      .c     (carry_q),
      .sum_i (dig_sum_s),
      .c_out (dig_carry_s)
   );

   // Flag any non-decimal nibble on either operand at the accept point.
   always_comb begin
      operand_err_s = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         operand_err_s = operand_err_s
                       | ~bcd_digit_ok(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                       | ~bcd_digit_ok(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
      end
   end

   // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      sub_d      = sub_q;
      carry_d    = carry_q;
      err_pend_d = err_pend_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      err_d      = err_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dig_wr_s   = err_pend_q ? 4'd0 : dig_sum_s;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               cnt_d      = '0;
               a_d        = a;
               b_d        = b;
               sub_d      = sub;
               carry_d    = sub ? ~cin : cin;
               err_pend_d = operand_err_s;
               sum_d      = '0;
               cout_d     = 1'b0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_RUN: begin
            // Result digits enter at the top and settle into place after DIGITS shifts.
            a_d     = a_q >> BCD_DIGIT_W;
            b_d     = b_q >> BCD_DIGIT_W;
            sum_d   = (sum_q >> BCD_DIGIT_W) | (W'(dig_wr_s) << (W - BCD_DIGIT_W));
            carry_d = dig_carry_s;
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
               err_d   = err_pend_q;
               cout_d  = err_pend_q ? 1'b0 : (sub_q ? ~dig_carry_s : dig_carry_s);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         carry_q    <= 1'b0;
         err_pend_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sub_q      <= sub_d;
         carry_q    <= carry_d;
         err_pend_q <= err_pend_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// Directed self-checking bench for bcd_seq_addsub with DIGITS = 4.
module tb_bcd_seq_addsub;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int t0     = 0;

   bcd_seq_addsub #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Present an operation and clock it in; returns #1 after the accepting edge.
   task automatic launch(input logic s, input logic c, input logic [W-1:0] av, input logic [W-1:0] bv);
      sub   = s;
      cin   = c;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   // Wait (bounded) for done, check result and latency, then step past the done cycle.
   task automatic finish_op(input string tag, input logic [W-1:0] exp_sum,
                            input logic exp_cout, input logic exp_err);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check_eq({tag, "_latency"}, 32'(cyc - t0 + 1), 32'(DIGITS + 1));
         check_eq({tag, "_sum"},  {16'd0, sum},  {16'd0, exp_sum});
         check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
         check_eq({tag, "_err"},  {31'd0, err},  {31'd0, exp_err});
         check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
         @(posedge clk);
         #1;
         check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
         check_eq({tag, "_busy_clr"},   {31'd0, busy}, 32'd0);
         check_eq({tag, "_sum_held"},   {16'd0, sum},  {16'd0, exp_sum});
      end
   endtask

   initial begin
      logic dseen;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_sum",  {16'd0, sum},  32'd0);
      check_eq("rst_cout", {31'd0, cout}, 32'd0);
      check_eq("rst_err",  {31'd0, err},  32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      launch(1'b0, 1'b0, 16'h9999, 16'h0001);
      finish_op("add_9999_0001", 16'h0000, 1'b1, 1'b0);

      launch(1'b1, 1'b0, 16'h1234, 16'h0567);
      finish_op("sub_1234_0567", 16'h0667, 1'b0, 1'b0);

      launch(1'b1, 1'b1, 16'h1234, 16'h0567);
      finish_op("sub_1234_0567_bin", 16'h0666, 1'b0, 1'b0);

      launch(1'b1, 1'b0, 16'h0100, 16'h0200);
      finish_op("sub_0100_0200", 16'h9900, 1'b1, 1'b0);

      launch(1'b0, 1'b0, 16'h12A4, 16'h0001);
      finish_op("add_err_a", 16'h0000, 1'b0, 1'b1);

      launch(1'b1, 1'b0, 16'h0001, 16'hF000);
      finish_op("sub_err_b", 16'h0000, 1'b0, 1'b1);

      // A second start during RUN must be ignored.
      launch(1'b1, 1'b0, 16'h1234, 16'h0567);
      @(posedge clk);
      #1;
      sub   = 1'b0;
      a     = 16'h9999;
      b     = 16'h9999;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      finish_op("ignore_start", 16'h0667, 1'b0, 1'b0);

      // Back-to-back: accepted in the first cycle after done.
      launch(1'b0, 1'b1, 16'h1234, 16'h4321);
      finish_op("b2b_add", 16'h5556, 1'b0, 1'b0);

      // Reset in the middle of RUN.
      launch(1'b0, 1'b0, 16'h1111, 16'h2222);
      @(posedge clk);
      #1;
      check_eq("partial_sum", {16'd0, sum}, 32'h0000_3000);
      rst = 1'b1;
      #1;
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_done", {31'd0, done}, 32'd0);
      check_eq("midrst_sum",  {16'd0, sum},  32'd0);
      check_eq("midrst_cout", {31'd0, cout}, 32'd0);
      check_eq("midrst_err",  {31'd0, err},  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      dseen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         dseen = dseen | done;
      end
      check_eq("no_done_after_rst", {31'd0, dseen}, 32'd0);

      launch(1'b0, 1'b0, 16'h0005, 16'h0005);
      finish_op("add_after_rst", 16'h0010, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
